// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory, the redirect source and decode.
// The fetch stage connects through the master modport; its environment uses the slave modport.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             id_valid;
    logic             id_ready;
    logic [WIDTH-1:0] id_instr;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_pc_plus4;

    // Handshakes: a transfer happens on a rising edge where valid && ready; a valid
    // source keeps its payload stable until then (a redirect may move imem_req_addr).
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, id_pc_plus4,
        output id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited word fetches, in-order response buffer tagged with PCs,
// and redirect handling that flushes the buffer and drops responses for stale requests.
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t        PTR_LAST = ptr_t'(DEPTH - 1);
    localparam logic [CW:0] CREDITS  = (CW + 1)'(DEPTH);

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
    endfunction

    logic             r_run;
    logic [WIDTH-1:0] r_pc;
    cnt_t             r_outstanding;
    cnt_t             r_drop_cnt;
    cnt_t             r_count;
    ptr_t             r_tag_wr;
    ptr_t             r_tag_rd;
    ptr_t             r_buf_wr;
    ptr_t             r_buf_rd;
    logic [WIDTH-1:0] r_tag_q     [DEPTH];
    logic [WIDTH-1:0] r_buf_instr [DEPTH];
    logic [WIDTH-1:0] r_buf_pc    [DEPTH];

    logic [CW:0]      w_used;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp;
    logic             w_drop;
    logic             w_keep;
    logic             w_id_valid;
    logic             w_pop;
    logic             w_redirect;
    cnt_t             w_out_next;

    // Every outstanding request owns a buffer slot, so responses never need backpressure.
    assign w_used      = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req_valid = r_run && (w_used < CREDITS);
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp       = bus.imem_rsp_valid;
    assign w_drop      = w_rsp && (r_drop_cnt != '0);
    assign w_keep      = w_rsp && (r_drop_cnt == '0);
    assign w_id_valid  = (r_count != '0);
    assign w_pop       = w_id_valid && bus.id_ready;
    assign w_redirect  = bus.redirect_valid;
    assign w_out_next  = r_outstanding + cnt_t'(w_req_fire) - cnt_t'(w_rsp);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_buf_wr      <= '0;
            r_buf_rd      <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_out_next;
            if (w_req_fire) r_tag_wr <= ptr_inc(r_tag_wr);
            if (w_rsp)      r_tag_rd <= ptr_inc(r_tag_rd);

            if (w_redirect) begin
                // Whatever is still in flight after this edge belongs to the old path.
                r_pc       <= {bus.redirect_pc[WIDTH-1:2], 2'b00};
                r_drop_cnt <= w_out_next;
                r_count    <= '0;
                r_buf_wr   <= '0;
                r_buf_rd   <= '0;
            end else begin
                if (w_req_fire) r_pc <= r_pc + WIDTH'(4);
                if (w_drop)     r_drop_cnt <= r_drop_cnt - cnt_t'(1);
                if (w_keep)     r_buf_wr <= ptr_inc(r_buf_wr);
                if (w_pop)      r_buf_rd <= ptr_inc(r_buf_rd);
                r_count <= r_count + cnt_t'(w_keep) - cnt_t'(w_pop);
            end
        end
    end

    // Storage needs no reset: pointers and counters decide what is live.
    always_ff @(posedge clk) begin
        if (w_req_fire) r_tag_q[r_tag_wr] <= r_pc;
        if (w_keep) begin
            r_buf_instr[r_buf_wr] <= bus.imem_rsp_data;
            r_buf_pc[r_buf_wr]    <= r_tag_q[r_tag_rd];
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.id_valid       = w_id_valid;
    assign bus.id_instr       = w_id_valid ? r_buf_instr[r_buf_rd] : '0;
    assign bus.id_pc          = w_id_valid ? r_buf_pc[r_buf_rd] : '0;
    assign bus.id_pc_plus4    = w_id_valid ? (r_buf_pc[r_buf_rd] + WIDTH'(4)) : '0;

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_used <= CREDITS);
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_drop_cnt <= r_outstanding);
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && (r_outstanding == '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: unit 0 (RESET_PC 0) gets directed and random traffic with redirects,
// unit 1 (RESET_PC 0xFFFF_FFF8) streams continuously to cover PC wrap-around.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.WIDTH(32)) bus0 ();
    fetch_unit_if #(.WIDTH(32)) bus1 ();

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master));
    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.master));

    int checks = 0;
    int failures = 0;

    // Unit 0 model: expected {pc, instr} deliveries and the memory's pending responses.
    logic [63:0] exp_q[$];
    logic [31:0] pend_addr_q[$];
    int          pend_due_q[$];
    logic [31:0] m_pc;
    int          cyc = 0;
    int          n_req = 0;
    int          req_ready_pct = 100;
    int          id_ready_pct = 100;
    int          redir_pct = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        force_redir = 1'b0;
    logic [31:0] force_target = '0;
    logic        redir_on_busy = 1'b0;
    logic        busy_hit = 1'b0;
    logic        prev_redir = 1'b0;
    logic        just_reset = 1'b0;
    logic        want_req = 1'b0;
    logic [31:0] want_req_addr = '0;
    logic        want_id = 1'b0;
    logic [31:0] want_id_pc = '0;

    // Unit 1 model: always-ready memory with one-cycle latency, decode always ready.
    logic [31:0] u1_pc;
    logic [31:0] u1_exp_pc;
    logic [31:0] u1_prev_addr;
    logic        u1_prev_fire;
    int          u1_nreq;
    logic [31:0] u1_first[3];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus0.imem_req_ready = 1'b0;
        bus0.imem_rsp_valid = 1'b0;
        bus0.imem_rsp_data  = '0;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc    = '0;
        bus0.id_ready       = 1'b0;
        bus1.imem_req_ready = 1'b0;
        bus1.imem_rsp_valid = 1'b0;
        bus1.imem_rsp_data  = '0;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = '0;
        bus1.id_ready       = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        repeat (n) @(negedge clk);
        chk("rst_req_valid", 64'(bus0.imem_req_valid), 64'(0));
        chk("rst_req_addr", 64'(bus0.imem_req_addr), 64'(32'h0000_0000));
        chk("rst_id_valid", 64'(bus0.id_valid), 64'(0));
        chk("rst_id_instr", 64'(bus0.id_instr), 64'(0));
        chk("rst_id_pc", 64'(bus0.id_pc), 64'(0));
        chk("rst_id_pc_plus4", 64'(bus0.id_pc_plus4), 64'(0));
        chk("rst_u1_req_valid", 64'(bus1.imem_req_valid), 64'(0));
        chk("rst_u1_req_addr", 64'(bus1.imem_req_addr), 64'(32'hFFFF_FFF8));
        chk("rst_u1_id_valid", 64'(bus1.id_valid), 64'(0));
        exp_q.delete();
        pend_addr_q.delete();
        pend_due_q.delete();
        m_pc = 32'h0000_0000;
        prev_redir = 1'b0;
        want_req = 1'b0;
        want_id = 1'b0;
        u1_pc = 32'hFFFF_FFF8;
        u1_exp_pc = 32'hFFFF_FFF8;
        u1_prev_fire = 1'b0;
        u1_prev_addr = '0;
        u1_nreq = 0;
        just_reset = 1'b1;
        rst_n = 1'b1;
    endtask

    // One clock: at the falling edge observe outputs, predict, and drive the next edge's inputs.
    task automatic cycle();
        logic        ready, idr, redir, fire, rsp, pop, busy;
        logic [31:0] target, rsp_addr, e_p4;
        logic [63:0] e;
        @(negedge clk);
        cyc++;
        if (just_reset) begin
            chk("first_req_u0", 64'(bus0.imem_req_valid), 64'(1));
            chk("first_req_u1", 64'(bus1.imem_req_valid), 64'(1));
            just_reset = 1'b0;
        end
        if (prev_redir) chk("flush_id_valid", 64'(bus0.id_valid), 64'(0));

        ready = ($urandom_range(99) < req_ready_pct);
        idr   = ($urandom_range(99) < id_ready_pct);
        rsp   = (pend_due_q.size() > 0) && (pend_due_q[0] <= cyc);
        fire  = bus0.imem_req_valid && ready;
        pop   = bus0.id_valid && idr;
        busy  = redir_on_busy && fire && rsp;
        redir = force_redir || busy || ($urandom_range(99) < redir_pct);
        target = force_redir ? force_target : $urandom;
        if (busy) begin
            busy_hit = 1'b1;
            redir_on_busy = 1'b0;
        end

        rsp_addr = '0;
        if (rsp) begin
            rsp_addr = pend_addr_q.pop_front();
            void'(pend_due_q.pop_front());
        end
        bus0.imem_req_ready = ready;
        bus0.id_ready       = idr;
        bus0.redirect_valid = redir;
        bus0.redirect_pc    = target;
        bus0.imem_rsp_valid = rsp;
        bus0.imem_rsp_data  = rsp ? mem_word(rsp_addr) : $urandom;

        if (pop) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL id_unexpected observed_pc=%h expected=no_delivery", bus0.id_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                e_p4 = e[63:32] + 32'd4;
                chk("id_pc", 64'(bus0.id_pc), 64'(e[63:32]));
                chk("id_instr", 64'(bus0.id_instr), 64'(e[31:0]));
                chk("id_pc_plus4", 64'(bus0.id_pc_plus4), 64'(e_p4));
                if (want_id) begin
                    chk("first_id_after_redirect", 64'(bus0.id_pc), 64'(want_id_pc));
                    want_id = 1'b0;
                end
            end
        end
        if (fire) begin
            chk("req_addr", 64'(bus0.imem_req_addr), 64'(m_pc));
            if (want_req) begin
                chk("first_req_after_redirect", 64'(bus0.imem_req_addr), 64'(want_req_addr));
                want_req = 1'b0;
            end
            n_req++;
            pend_addr_q.push_back(m_pc);
            pend_due_q.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            if (!redir) exp_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            m_pc = {target[31:2], 2'b00};
        end
        prev_redir = redir;

        bus1.imem_req_ready = 1'b1;
        bus1.id_ready       = 1'b1;
        bus1.redirect_valid = 1'b0;
        bus1.imem_rsp_valid = u1_prev_fire;
        bus1.imem_rsp_data  = mem_word(u1_prev_addr);
        if (bus1.id_valid) begin
            e_p4 = u1_exp_pc + 32'd4;
            chk("u1_id_pc", 64'(bus1.id_pc), 64'(u1_exp_pc));
            chk("u1_id_instr", 64'(bus1.id_instr), 64'(mem_word(u1_exp_pc)));
            chk("u1_id_pc_plus4", 64'(bus1.id_pc_plus4), 64'(e_p4));
            if (u1_exp_pc == 32'hFFFF_FFFC) chk("u1_wrap_plus4", 64'(bus1.id_pc_plus4), 64'(0));
            u1_exp_pc = u1_exp_pc + 32'd4;
        end
        u1_prev_fire = bus1.imem_req_valid;
        if (bus1.imem_req_valid) begin
            chk("u1_req_addr", 64'(bus1.imem_req_addr), 64'(u1_pc));
            if (u1_nreq < 3) chk("u1_first_addr", 64'(bus1.imem_req_addr), 64'(u1_first[u1_nreq]));
            u1_prev_addr = u1_pc;
            u1_pc = u1_pc + 32'd4;
            u1_nreq++;
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        req_ready_pct = 0;
        id_ready_pct = 100;
        redir_pct = 0;
        budget = 0;
        while ((exp_q.size() != 0 || pend_addr_q.size() != 0) && budget < 60) begin
            cycle();
            budget++;
        end
        chk(tag, 64'(exp_q.size() + pend_addr_q.size()), 64'(0));
    endtask

    initial begin
        int n0;
        int budget;
        u1_first[0] = 32'hFFFF_FFF8;
        u1_first[1] = 32'hFFFF_FFFC;
        u1_first[2] = 32'h0000_0000;
        drive_idle();
        do_reset(3);

        // Decode stalled from reset: only DEPTH requests may go out, head holds PC 0.
        req_ready_pct = 100; id_ready_pct = 0; lat_min = 1; lat_max = 1;
        n0 = n_req;
        repeat (10) cycle();
        chk("stall_req_count", 64'(n_req - n0), 64'(2));
        chk("stall_req_valid", 64'(bus0.imem_req_valid), 64'(0));
        chk("stall_id_valid", 64'(bus0.id_valid), 64'(1));
        chk("stall_id_pc", 64'(bus0.id_pc), 64'(0));
        chk("stall_id_instr", 64'(bus0.id_instr), 64'(mem_word(32'h0)));

        // Release and stream sequential fetches.
        id_ready_pct = 100;
        repeat (30) cycle();
        drain("drain_before_redirect");

        // Two long-latency requests in flight, then redirect to a misaligned target.
        req_ready_pct = 100; lat_min = 6; lat_max = 6;
        n0 = n_req;
        budget = 0;
        while (n_req < n0 + 2 && budget < 10) begin
            cycle();
            budget++;
        end
        chk("two_outstanding", 64'(n_req - n0), 64'(2));
        force_redir = 1'b1; force_target = 32'h0000_0203;
        cycle();
        force_redir = 1'b0;
        lat_min = 1; lat_max = 1;
        want_req = 1'b1; want_req_addr = 32'h0000_0200;
        want_id = 1'b1; want_id_pc = 32'h0000_0200;
        repeat (25) cycle();
        chk("redirect_req_seen", 64'(want_req), 64'(0));
        chk("redirect_id_seen", 64'(want_id), 64'(0));

        // Redirect in the same cycle as a request acceptance and a response arrival.
        busy_hit = 1'b0; redir_on_busy = 1'b1;
        budget = 0;
        while (!busy_hit && budget < 20) begin
            cycle();
            budget++;
        end
        redir_on_busy = 1'b0;
        chk("busy_redirect_hit", 64'(busy_hit), 64'(1));
        repeat (10) cycle();

        // Random handshakes, response latencies and redirects.
        req_ready_pct = 70; id_ready_pct = 60; redir_pct = 2; lat_min = 1; lat_max = 4;
        repeat (4000) cycle();
        drain("drain_after_random");

        // Reset in the middle of streaming traffic.
        req_ready_pct = 100; id_ready_pct = 100; lat_min = 1; lat_max = 3;
        repeat (7) cycle();
        do_reset(2);
        req_ready_pct = 100; id_ready_pct = 80; lat_min = 1; lat_max = 2;
        repeat (40) cycle();
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
